// File: rtl/oram_axi_wr_slave.sv
// Single-outstanding AXI-style write responder: AW -> W beats -> B, writing beats into the output RAM.
// Optional macro ORAM_WR_SLV_ERRINJ_EN adds an errinj input that forces SLVERR on the accepted burst.
module oram_axi_wr_slave #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int RAM_DEPTH  = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         awvld,
  output logic                         awrdy,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
`ifdef ORAM_WR_SLV_ERRINJ_EN
  input  logic                         errinj,
`endif
  input  logic                         wvld,
  output logic                         wrdy,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic [11:0]                  w_oram_addr,
  output logic                         bvld,
  input  logic                         brdy,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic [11:0]                  b_oram_addr,
  output logic                         ram_wen,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]        ram_wdata,
  output logic [DATA_WIDTH/8-1:0]      ram_wstrb
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_e;

  localparam logic [31:0] DEPTH_L = 32'(RAM_DEPTH);

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            burst_q, burst_d;
  logic [6:0]            base_q, base_d;
  logic                  err_q, err_d;
  logic                  inj_q, inj_d;
  logic [11:0]           boram_q, boram_d;

  logic [8:0]            beat_addr_s;
  logic                  in_range_s;
  logic                  beat_s;
  logic                  aw_bad_s;
  logic                  inj_in_s;
  logic                  unused_s;

`ifdef ORAM_WR_SLV_ERRINJ_EN
  assign inj_in_s = errinj;
`else
  assign inj_in_s = 1'b0;
`endif

  // wlast is deliberately ignored: awlen alone terminates the burst.
  assign unused_s = wlast;

  // 9-bit beat address never wraps, so anything past the RAM is caught by the range check.
  assign beat_addr_s = (burst_q == 2'b00) ? {2'b00, base_q}
                                          : ({2'b00, base_q} + {1'b0, cnt_q});
  assign in_range_s  = ({23'd0, beat_addr_s} < DEPTH_L);
  assign beat_s      = (state_q == DATA) && wvld;
  assign aw_bad_s    = (awsize != 3'd3) || (awaddr[2:0] != 3'd0) || (awburst[1] == 1'b1);

  assign awrdy       = (state_q == IDLE);
  assign wrdy        = (state_q == DATA);
  assign bvld        = (state_q == RESP);
  assign bid         = id_q;
  assign bresp       = ((state_q == RESP) && (err_q || inj_q)) ? 2'b10 : 2'b00;
  assign b_oram_addr = boram_q;

  assign ram_wen     = beat_s && !err_q && in_range_s;
  assign ram_addr    = beat_addr_s[$clog2(RAM_DEPTH)-1:0];
  assign ram_wdata   = wdata;
  assign ram_wstrb   = wstrb;

  // Burst state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      burst_q <= 2'b00;
      base_q  <= 7'd0;
      err_q   <= 1'b0;
      inj_q   <= 1'b0;
      boram_q <= 12'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      base_q  <= base_d;
      err_q   <= err_d;
      inj_q   <= inj_d;
      boram_q <= boram_d;
    end
  end

  // Next-state logic for the AW / W / B sequence.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    base_d  = base_q;
    err_d   = err_q;
    inj_d   = inj_q;
    boram_d = boram_q;
    case (state_q)
      IDLE: begin
        if (awvld) begin
          id_d    = awid;
          len_d   = awlen;
          burst_d = awburst;
          base_d  = awaddr[9:3];
          cnt_d   = 8'd0;
          err_d   = aw_bad_s;
          inj_d   = inj_in_s;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (wvld) begin
          cnt_d = cnt_q + 8'd1;
          if (!in_range_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (cnt_q == 8'd0) begin
            boram_d = w_oram_addr;
          end else begin
            boram_d = boram_q;
          end
          if (cnt_q == len_q) begin
            state_d = RESP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        if (brdy) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/oram_axi_wr_slave.md
# oram_axi_wr_slave

AXI-style write responder that terminates the LSU store path on the output-RAM side. It accepts one write burst at a time (AW, then W beats, then B), writes the beat data into the output RAM, and returns a per-burst response tagged with the ORAM address of the burst's first beat. A non-OKAY response tells the store buffer to resend that burst.

## Interface
- `ID_WIDTH`, default 8: AW ID width.
- `ADDR_WIDTH`, default 10: byte address width.
- `DATA_WIDTH`, default 64: W data width; 8 bytes per beat.
- `RAM_DEPTH`, default 128: number of output-RAM words.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous and active-high.
- `awvld` in 1, `awrdy` out 1: AW handshake.
- `awid` in ID_WIDTH; `awaddr` in ADDR_WIDTH; `awlen` in 8; `awsize` in 3; `awburst` in 2: burst attributes.
- `wvld` in 1, `wrdy` out 1: W handshake.
- `wdata` in 64; `wstrb` in 8; `wlast` in 1 (ignored); `w_oram_addr` in 12: beat payload.
- `bvld` out 1, `brdy` in 1: B handshake.
- `bid` out ID_WIDTH; `bresp` out 2; `b_oram_addr` out 12: response payload.
- `ram_wen` out 1; `ram_addr` out log2(RAM_DEPTH); `ram_wdata` out 64; `ram_wstrb` out 8: output-RAM write port.

## Operation
FSM states: IDLE, DATA, RESP.
- **IDLE**
  - `awrdy`=1.
  - On `awvld&awrdy`, latch `awid`, `awlen`, `awburst` and word address `awaddr[9:3]`.
  - Clear the beat counter and the error flag, then go to DATA.
  - Latch the error flag if any of these hold: `awsize`≠3, `awaddr[2:0]`≠0, or `awburst`∉{00,01}.
- **DATA**
  - `wrdy`=1.
  - Each `wvld&wrdy` is one beat, and beat count b = 0..awlen.
  - Beat word address is base for FIXED (00) and base+b for INCR (01). Compute it 9 bits wide with no wrap.
  - If the error flag is clear and the beat address is < RAM_DEPTH: drive `ram_wen`=1, with `ram_addr`, `ram_wdata`=`wdata` and `ram_wstrb`=`wstrb`, all in the same cycle as the beat.
  - If the beat address is ≥ RAM_DEPTH: suppress the write and set the error flag. Later beats of the burst are still consumed.
  - Latch `w_oram_addr` on beat 0 into `b_oram_addr`.
  - After beat awlen (awlen+1 beats total), go to RESP. `wlast` is never used for burst termination.
- **RESP**
  - `bvld`=1, `bid`=latched ID, `bresp`=10 (SLVERR) if the error flag is set, else 00.
  - Payload stays stable until `bvld&brdy`, then go to IDLE.
- AW arriving in DATA or RESP is not accepted (`awrdy`=0) and must be held by the initiator.

## Timing
- Reset values: state IDLE, `awrdy`=1, `wrdy`=0, `bvld`=0, `bresp`=00, `bid`=0, `b_oram_addr`=0, `ram_wen`=0, error flag 0, beat counter 0.
- AW handshake in cycle t: `wrdy`=1 from t+1. There are no data bubbles; one beat per cycle at full rate.
- Last beat in cycle t: `bvld`=1 from t+1.
- B handshake in cycle t: `awrdy`=1 from t+1. Minimum burst occupancy is awlen+3 cycles.
- `ram_wen` is combinational from `wvld&wrdy` and the address check. All other outputs are decoded from state or registered.
- `brdy` held high: the handshake completes in the first `bvld` cycle.
- `wvld` low in DATA: the beat counter holds and there is no RAM write.
- Reset mid-burst: return to IDLE immediately with no B response. Words already written stay in the RAM.
- awlen=0: a single beat, then RESP.

## Configuration
- `ORAM_WR_SLV_ERRINJ_EN`
  - **Defined:** adds input `errinj` (1 bit). If `errinj`=1 in the AW handshake cycle, that burst returns SLVERR. Its RAM writes still occur. This exercises store-buffer resend.
  - **Undefined:** no port, and behaviour is exactly as above.

## Test plan
- **Legal INCR burst:** AW awaddr=0x040, awlen=3, awsize=3, awburst=01; beats D0..D3 with `w_oram_addr`=0x012 on beat 0. Expect `ram_addr` 8,9,10,11 with matching data; `bvld` one cycle after beat 3; `bresp`=00; `b_oram_addr`=0x012.
- **Out of range:** awaddr=0x3F8 (word 127), awlen=1. Expect word 127 written; beat 1 not written; `bresp`=10.
- **Bad size:** awsize=2. Expect all beats accepted; `ram_wen` never asserted; `bresp`=10.
- **Backpressure:** `wvld` gaps of 2 cycles and `brdy` low for 5 cycles. Expect no extra writes; B payload stable; a second `awvld` is not accepted until the cycle after the B handshake.
- **Reset mid-burst:** `rst` pulse after beat 1 of 4. Expect `awrdy`=1, `bvld`=0, and a new burst that completes normally.
- **Error injection:** with `ORAM_WR_SLV_ERRINJ_EN` defined, `errinj`=1 on AW. Expect data written and `bresp`=10.
